// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multi-cycle RV64I control FSM (R/I ALU, ld, sd, beq); CTRL_PERF_EN adds cycle/instret counters
module multicycle_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        pc_we,
  output logic        pc_src,
  output logic        ir_we,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic        reg_we,
  output logic        alu_src_b,
  output logic [1:0]  alu_op,
  output logic        wb_sel,
  output logic [2:0]  state,
  output logic        illegal
`ifdef CTRL_PERF_EN
  ,
  output logic [63:0] cycle_cnt,
  output logic [63:0] instret_cnt
`endif
);
  localparam logic [2:0] FETCH = 3'd0, DECODE = 3'd1, EXEC = 3'd2, MEM = 3'd3,
                         WB = 3'd4, BRANCH = 3'd5, TRAP = 3'd6;
  localparam logic [2:0] C_R = 3'd0, C_I = 3'd1, C_LD = 3'd2, C_SD = 3'd3,
                         C_BEQ = 3'd4, C_BAD = 3'd7;
  logic [2:0] nxt, cls, dcls;
  logic fe, ex, me, wb, br, is_ld, is_sd;
  assign dcls = opcode == 7'b0110011 ? C_R :
                opcode == 7'b0010011 ? C_I :
                (opcode == 7'b0000011 && funct3 == 3'b011) ? C_LD :
                (opcode == 7'b0100011 && funct3 == 3'b011) ? C_SD :
                (opcode == 7'b1100011 && funct3 == 3'b000) ? C_BEQ : C_BAD;
  always_comb begin
    nxt = FETCH;
    case (state)
      FETCH:  nxt = mem_ready ? DECODE : FETCH;
      DECODE: nxt = dcls == C_BAD ? TRAP : dcls == C_BEQ ? BRANCH : EXEC;
      EXEC:   nxt = (is_ld || is_sd) ? MEM : WB;
      MEM:    nxt = mem_ready ? (is_ld ? WB : FETCH) : MEM;
      TRAP:   nxt = TRAP;
      default: nxt = FETCH;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= FETCH;
      cls   <= C_R;
    end else begin
      state <= nxt;
      if (state == DECODE && dcls != C_BAD) cls <= dcls;
    end
  assign fe    = state == FETCH;
  assign ex    = state == EXEC;
  assign me    = state == MEM;
  assign wb    = state == WB;
  assign br    = state == BRANCH;
  assign is_ld = cls == C_LD;
  assign is_sd = cls == C_SD;
  // Every output is gated by rst_n so a pending request drops the instant reset asserts
  assign pc_we     = rst_n & ((fe & mem_ready) | (br & zero));
  assign pc_src    = rst_n & br & zero;
  assign ir_we     = rst_n & fe & mem_ready;
  assign mem_rd    = rst_n & (fe | (me & is_ld));
  assign mem_wr    = rst_n & me & is_sd;
  assign reg_we    = rst_n & wb;
  assign alu_src_b = rst_n & ((ex & cls != C_R) | me);
  assign alu_op    = !rst_n ? 2'b00 : (ex & (cls == C_R | cls == C_I)) ? 2'b10 : br ? 2'b01 : 2'b00;
  assign wb_sel    = rst_n & wb & is_ld;
  assign illegal   = state == TRAP;
`ifdef CTRL_PERF_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cycle_cnt   <= '0;
      instret_cnt <= '0;
    end else begin
      if (state != TRAP) cycle_cnt <= cycle_cnt + 64'd1;
      if (wb | br | (me & is_sd & mem_ready)) instret_cnt <= instret_cnt + 64'd1;
    end
`endif
endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multi-cycle control FSM for the RV64I datapath (PC, program/data memory, register file, ALU). It replaces the free-running PC update: it sequences each instruction through fetch, decode, execute, memory and writeback. It produces every write enable and mux select the datapath needs, and it stalls on a memory ready handshake. It supports a subset: R-type ALU, I-type ALU, `ld`, `sd` and `beq`. Any other encoding traps.

## Interface
Parameters: none.
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `opcode` in 7: instruction[6:0], taken from the instruction register output.
- `funct3` in 3: instruction[14:12].
- `zero` in 1: ALU zero flag.
- `mem_ready` in 1: the memory completes the current access this cycle.
- `pc_we` out 1: PC register load enable.
- `pc_src` out 1: PC input select. 0 = PC+4, 1 = branch target.
- `ir_we` out 1: instruction register load enable.
- `mem_rd` out 1: memory read request.
- `mem_wr` out 1: memory write request.
- `reg_we` out 1: register-file write enable (drives the datapath `flag`).
- `alu_src_b` out 1: ALU operand B select. 0 = rs2, 1 = immediate.
- `alu_op` out 2: 00 = add, 01 = sub, 10 = function decoded from funct3/funct7.
- `wb_sel` out 1: writeback data select. 0 = ALU, 1 = memory.
- `state` out 3: current state encoding, for debug.
- `illegal` out 1: sticky trap indicator.
- `cycle_cnt` out 64: present only with `CTRL_PERF_EN`.
- `instret_cnt` out 64: present only with `CTRL_PERF_EN`.

## Operation
- **State encoding:** FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, BRANCH=5, TRAP=6. Encoding 7 is unreachable; if it is ever entered, the next state is FETCH.
- **Instruction class register:** a 3-bit register, `cls`, is loaded in DECODE. It holds one of R, I, LD, SD, BEQ.
- **FETCH:**
  - `mem_rd`=1.
  - When `mem_ready`=1: `ir_we`=1, `pc_we`=1, `pc_src`=0, and the FSM moves to DECODE.
  - Otherwise the FSM stays in FETCH.
  - `ir_we` and `pc_we` are Mealy outputs that depend on `mem_ready`.
- **DECODE:** lasts one cycle and captures `cls`. Decode rules:
  - 0110011 → R, next state EXEC.
  - 0010011 → I, next state EXEC.
  - 0000011 with funct3=011 → LD, next state EXEC.
  - 0100011 with funct3=011 → SD, next state EXEC.
  - 1100011 with funct3=000 → BEQ, next state BRANCH.
  - Anything else → TRAP.
- **EXEC:** lasts one cycle.
  - R: `alu_src_b`=0, `alu_op`=10.
  - I: `alu_src_b`=1, `alu_op`=10.
  - LD/SD: `alu_src_b`=1, `alu_op`=00.
  - Next state: WB for R/I, MEM for LD/SD.
- **MEM:**
  - `mem_rd`=1 for LD; `mem_wr`=1 for SD. The address operands stay selected as in EXEC.
  - The request is held until `mem_ready`=1.
  - Then LD → WB and SD → FETCH.
- **WB:** lasts one cycle. `reg_we`=1, `wb_sel`=1 for LD and 0 otherwise. Next state FETCH.
- **BRANCH:** lasts one cycle. `alu_op`=01, `alu_src_b`=0.
  - If `zero`=1: `pc_we`=1, `pc_src`=1.
  - Next state FETCH in both cases.
  - The datapath computes the target from the old PC it latched at fetch.
- **TRAP:**
  - `illegal`=1. All enables and requests are 0.
  - The FSM stays in TRAP until `rst_n` is asserted.
- **Idle output values:** in every state, any output not named above is 0.

## Timing
- **While `rst_n`=0:** state=FETCH, `cls`=R, `illegal`=0, counters=0, and every output forced to 0, including `mem_rd`.
  - `mem_rd` first rises in the first cycle after `rst_n` deasserts.
- **Reset mid-operation:** asserting `rst_n` in any state, including MEM with a request pending, aborts at once. The request drops asynchronously and there is no writeback.
- **Latency with zero-wait memory:**
  - R/I: 4 cycles.
  - `ld`: 5 cycles.
  - `sd`: 4 cycles.
  - `beq`: 3 cycles.
  - Each cycle with `mem_ready`=0 in FETCH or MEM adds one cycle.
- **Memory handshake:**
  - A request stays stable until the cycle in which `mem_ready` is sampled high.
  - `mem_ready` outside FETCH/MEM is ignored.
  - `mem_rd` and `mem_wr` are never both high.
- **`reg_we`** is high for exactly one cycle per R/I/LD instruction.
- **`pc_we`** is high at most once per fetch, plus once for a taken branch.

## Configuration
- **With `CTRL_PERF_EN` defined:**
  - `cycle_cnt` increments on every clock while not in TRAP.
  - `instret_cnt` increments in WB, in a MEM cycle that completes a store, and in BRANCH.
  - Both counters wrap modulo 2^64 and reset to 0.
- **Without `CTRL_PERF_EN`:** both ports and both counters are absent. The FSM behaviour is identical.

## Test plan
- **Reset:** hold `rst_n`=0 for 3 cycles with `mem_ready`=1 → all outputs 0 and `state`=0. After release, `mem_rd`=1 in the first cycle.
- **`add`:** opcode 0110011, zero-wait memory → states 0,1,2,4. `reg_we`=1 in cycle 4 only, with `wb_sel`=0 and `alu_op`=10.
- **`ld` with wait states:** funct3=011, `mem_ready` low for 2 cycles in MEM → `mem_rd` held for 3 MEM cycles. Then WB with `wb_sel`=1. Total 7 cycles.
- **`beq`:** taken with `zero`=1 → `pc_we`=1 and `pc_src`=1 in BRANCH. Not taken with `zero`=0 → `pc_we`=0. Both cases return to FETCH after 3 cycles.
- **Illegal encoding:** opcode 1111111 → TRAP with `illegal`=1. No enables for 20 cycles. Cleared only by `rst_n`.
- **Perf counters (`CTRL_PERF_EN`):** run `add`, `sd`, `beq` with zero-wait memory → `instret_cnt`=3 and `cycle_cnt`=11. Reset mid-MEM → both counters 0.
